alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for a shared 16-bit ALU: single-cycle ALU ops, CMP,
// and a 16-iteration shift-add unsigned multiply with a valid/ready handshake.
module alu_seq_ctrl #(
    parameter logic [1:0] OP_AND = 2'b00,
    parameter logic [1:0] OP_OR  = 2'b01,
    parameter logic [1:0] OP_ADD = 2'b10
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        InValid,
    output logic        InReady,
    input  logic [2:0]  Cmd,
    input  logic [15:0] OpA,
    input  logic [15:0] OpB,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [15:0] ResLo,
    output logic [15:0] ResHi,
    output logic        ZeroFlag,
    output logic        CarryFlag,
    output logic        Err,
    output logic [15:0] AluA,
    output logic [15:0] AluB,
    output logic [1:0]  AluOp,
    output logic        AluBNegate,
    input  logic [15:0] AluResult,
    input  logic        AluZero,
    input  logic        AluCarryOut
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

    localparam logic [2:0] CMD_ADD = 3'b000;
    localparam logic [2:0] CMD_SUB = 3'b001;
    localparam logic [2:0] CMD_AND = 3'b010;
    localparam logic [2:0] CMD_OR  = 3'b011;
    localparam logic [2:0] CMD_MUL = 3'b100;
    localparam logic [2:0] CMD_CMP = 3'b101;

    state_t      r_state, w_next_state;
    logic [2:0]  r_cmd;
    logic [15:0] r_opa;      // operand A, also the multiplicand
    logic [15:0] r_mplr;     // operand B; shifts as the multiplier during MUL
    logic [15:0] r_acc;
    logic [3:0]  r_cnt;
    logic [15:0] r_res_lo, r_res_hi;
    logic        r_zero, r_carry, r_err;

    logic        w_accept, w_legal, w_last_iter;
    logic [15:0] w_mul_acc, w_mul_mplr;

    assign w_accept    = InValid && (r_state == S_IDLE);
    assign w_legal     = (Cmd <= CMD_CMP);
    assign w_last_iter = (r_cnt == 4'hF);
    assign w_mul_acc   = {AluCarryOut, AluResult[15:1]};
    assign w_mul_mplr  = {AluResult[0], r_mplr[15:1]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        AluA         = '0;
        AluB         = '0;
        AluOp        = OP_AND;
        AluBNegate   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_legal)            w_next_state = S_DONE;
                    else if (Cmd == CMD_MUL) w_next_state = S_MUL;
                    else                     w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                AluA = r_opa;
                AluB = r_mplr;
                case (r_cmd)
                    CMD_AND: AluOp = OP_AND;
                    CMD_OR:  AluOp = OP_OR;
                    CMD_SUB, CMD_CMP: begin
                        AluOp      = OP_ADD;
                        AluBNegate = 1'b1;
                    end
                    default: AluOp = OP_ADD;
                endcase
                w_next_state = S_DONE;
            end
            S_MUL: begin
                AluA  = r_acc;
                AluB  = r_mplr[0] ? r_opa : 16'h0000;
                AluOp = OP_ADD;
                if (w_last_iter) w_next_state = S_DONE;
            end
            S_DONE: begin
                if (OutReady) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cmd     <= '0;
            r_opa     <= '0;
            r_mplr    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_res_lo  <= '0;
            r_res_hi  <= '0;
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cmd  <= Cmd;
                        r_opa  <= OpA;
                        r_mplr <= OpB;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                        r_err  <= !w_legal;
                        if (!w_legal) begin
                            r_res_lo <= '0;
                            r_res_hi <= '0;
                            r_zero   <= 1'b0;
                            r_carry  <= 1'b0;
                        end
                    end
                end
                S_EXEC: begin
                    r_res_lo <= (r_cmd == CMD_CMP) ? 16'h0000 : AluResult;
                    r_res_hi <= '0;
                    r_zero   <= AluZero;
                    r_carry  <= AluCarryOut;
                end
                S_MUL: begin
                    r_acc  <= w_mul_acc;
                    r_mplr <= w_mul_mplr;
                    r_cnt  <= r_cnt + 4'd1;
                    if (w_last_iter) begin
                        r_res_hi <= w_mul_acc;
                        r_res_lo <= w_mul_mplr;
                        r_zero   <= ({w_mul_acc, w_mul_mplr} == 32'h0);
                        r_carry  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign InReady   = (r_state == S_IDLE);
    assign OutValid  = (r_state == S_DONE);
    assign ResLo     = r_res_lo;
    assign ResHi     = r_res_hi;
    assign ZeroFlag  = r_zero;
    assign CarryFlag = r_carry;
    assign Err       = r_err;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: models the shared ALU, applies a vector
// table, hand-written reset sequences and random requests against a reference model.
module tb_alu_seq_ctrl;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;

    logic        Clock, Reset_n, InValid, InReady, OutValid, OutReady;
    logic [2:0]  Cmd;
    logic [15:0] OpA, OpB, ResLo, ResHi, AluA, AluB, AluResult;
    logic        ZeroFlag, CarryFlag, Err, AluBNegate, AluZero, AluCarryOut;
    logic [1:0]  AluOp;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq_ctrl #(.OP_AND(OP_AND), .OP_OR(OP_OR), .OP_ADD(OP_ADD)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
        .Cmd(Cmd), .OpA(OpA), .OpB(OpB), .OutValid(OutValid), .OutReady(OutReady),
        .ResLo(ResLo), .ResHi(ResHi), .ZeroFlag(ZeroFlag), .CarryFlag(CarryFlag),
        .Err(Err), .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluBNegate(AluBNegate),
        .AluResult(AluResult), .AluZero(AluZero), .AluCarryOut(AluCarryOut)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Shared combinational ALU seen by the controller
    always_comb begin
        logic [16:0] sum;
        sum         = '0;
        AluResult   = '0;
        AluCarryOut = 1'b0;
        case (AluOp)
            OP_AND: AluResult = AluA & AluB;
            OP_OR:  AluResult = AluA | AluB;
            OP_ADD: begin
                sum = {1'b0, AluA} + {1'b0, (AluBNegate ? ~AluB : AluB)} + {16'h0, AluBNegate};
                AluResult   = sum[15:0];
                AluCarryOut = sum[16];
            end
            default: AluResult = '0;
        endcase
        AluZero = (AluResult == 16'h0);
    end

    typedef struct {
        logic [15:0] lo, hi;
        logic        z, c, err;
        int          lat;
    } exp_t;

    typedef struct {
        string       name;
        logic [2:0]  cmd;
        logic [15:0] a, b;
        int          stall;
        exp_t        e;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [2:0] cmd, input logic [15:0] a, input logic [15:0] b);
        exp_t        m;
        logic [16:0] s;
        logic [31:0] p;
        m = '{lo: 16'h0, hi: 16'h0, z: 1'b0, c: 1'b0, err: 1'b0, lat: 2};
        case (cmd)
            3'd0: begin
                s    = {1'b0, a} + {1'b0, b};
                m.lo = s[15:0];
                m.c  = s[16];
                m.z  = (s[15:0] == 16'h0);
            end
            3'd1: begin
                m.lo = a - b;
                m.c  = (a >= b);
                m.z  = (a == b);
            end
            3'd2: begin m.lo = a & b; m.z = ((a & b) == 16'h0); end
            3'd3: begin m.lo = a | b; m.z = ((a | b) == 16'h0); end
            3'd4: begin
                p     = {16'h0, a} * {16'h0, b};
                m.hi  = p[31:16];
                m.lo  = p[15:0];
                m.z   = (p == 32'h0);
                m.lat = 17;
            end
            3'd5: begin
                m.c = (a >= b);
                m.z = (a == b);
            end
            default: begin m.err = 1'b1; m.lat = 1; end
        endcase
        return m;
    endfunction

    task automatic check_idle_alu(input string name);
        check({name, ".alu_ctrl"}, {AluA, AluB, AluOp, AluBNegate}, {16'h0, 16'h0, OP_AND, 1'b0});
    endtask

    // Presents one request, then scrambles the operand bus and waits for the result.
    task automatic start_and_wait(input string name, input logic [2:0] cmd,
                                  input logic [15:0] a, input logic [15:0] b, output int lat);
        @(negedge Clock);
        check({name, ".in_ready"}, InReady, 1'b1);
        InValid = 1'b1; Cmd = cmd; OpA = a; OpB = b;
        @(posedge Clock); #1;
        InValid = 1'b0; OpA = 16'($urandom); OpB = 16'($urandom); Cmd = 3'($urandom);
        lat = 1;
        while (OutValid !== 1'b1 && lat < 40) begin
            @(posedge Clock); #1;
            lat++;
        end
    endtask

    task automatic run_txn(input string name, input logic [2:0] cmd, input logic [15:0] a,
                           input logic [15:0] b, input int stall, input exp_t e);
        int lat;
        start_and_wait(name, cmd, a, b, lat);
        check({name, ".latency"}, lat, e.lat);
        check({name, ".result"}, {ResHi, ResLo}, {e.hi, e.lo});
        check({name, ".flags"}, {ZeroFlag, CarryFlag, Err}, {e.z, e.c, e.err});
        for (int i = 0; i < stall; i++) begin
            @(negedge Clock);
            InValid = 1'b1; Cmd = 3'($urandom); OpA = 16'($urandom); OpB = 16'($urandom);
            @(posedge Clock); #1;
            check({name, ".hold_result"}, {ResHi, ResLo, ZeroFlag, CarryFlag, Err},
                  {e.hi, e.lo, e.z, e.c, e.err});
            check({name, ".hold_hs"}, {OutValid, InReady}, 2'b10);
        end
        @(negedge Clock);
        InValid = 1'b0; OutReady = 1'b1;
        @(posedge Clock); #1;
        OutReady = 1'b0;
        check({name, ".release"}, {OutValid, InReady}, 2'b01);
    endtask

    vec_t vecs[11];

    initial begin
        int lat;
        exp_t e;
        logic [2:0] rc;
        logic [15:0] ra, rb;

        vecs[0]  = '{"add_wrap",  3'b000, 16'hFFFF, 16'h0001, 0, '{16'h0000, 16'h0000, 1, 1, 0, 2}};
        vecs[1]  = '{"sub_borrow",3'b001, 16'h0005, 16'h0007, 0, '{16'hFFFE, 16'h0000, 0, 0, 0, 2}};
        vecs[2]  = '{"sub_pos",   3'b001, 16'h0007, 16'h0005, 0, '{16'h0002, 16'h0000, 0, 1, 0, 2}};
        vecs[3]  = '{"cmp_eq",    3'b101, 16'h1234, 16'h1234, 0, '{16'h0000, 16'h0000, 1, 1, 0, 2}};
        vecs[4]  = '{"and",       3'b010, 16'hF0F0, 16'h0FF0, 0, '{16'h00F0, 16'h0000, 0, 0, 0, 2}};
        vecs[5]  = '{"or_stall",  3'b011, 16'h1200, 16'h0034, 5, '{16'h1234, 16'h0000, 0, 0, 0, 2}};
        vecs[6]  = '{"mul_max",   3'b100, 16'hFFFF, 16'hFFFF, 0, '{16'h0001, 16'hFFFE, 0, 0, 0, 17}};
        vecs[7]  = '{"mul_zero",  3'b100, 16'h0000, 16'hABCD, 0, '{16'h0000, 16'h0000, 1, 0, 0, 17}};
        vecs[8]  = '{"mul_small", 3'b100, 16'h0003, 16'h0005, 2, '{16'h000F, 16'h0000, 0, 0, 0, 17}};
        vecs[9]  = '{"illegal6",  3'b110, 16'h1111, 16'h2222, 0, '{16'h0000, 16'h0000, 0, 0, 1, 1}};
        vecs[10] = '{"illegal7",  3'b111, 16'hFFFF, 16'hFFFF, 1, '{16'h0000, 16'h0000, 0, 0, 1, 1}};

        Reset_n = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        Cmd = '0; OpA = '0; OpB = '0;
        #12;
        check("reset.hs", {InReady, OutValid}, 2'b10);
        check("reset.outputs", {ResHi, ResLo, ZeroFlag, CarryFlag, Err}, 35'h0);
        check_idle_alu("reset");
        @(posedge Clock); #3; Reset_n = 1'b1;

        foreach (vecs[i]) run_txn(vecs[i].name, vecs[i].cmd, vecs[i].a, vecs[i].b,
                                  vecs[i].stall, vecs[i].e);
        check_idle_alu("after_table");

        // Reset mid-multiply: discards the operation and clears the last result
        run_txn("or_before_rst", 3'b011, 16'h1200, 16'h0034, 0, model(3'b011, 16'h1200, 16'h0034));
        @(negedge Clock);
        InValid = 1'b1; Cmd = 3'b100; OpA = 16'hFFFF; OpB = 16'hFFFF;
        @(posedge Clock); #1;
        InValid = 1'b0;
        repeat (8) @(posedge Clock);
        #2; Reset_n = 1'b0; #1;
        check("rst_mul.hs", {InReady, OutValid}, 2'b10);
        check("rst_mul.outputs", {ResHi, ResLo, ZeroFlag, CarryFlag, Err}, 35'h0);
        check_idle_alu("rst_mul");
        @(posedge Clock); #3; Reset_n = 1'b1;
        run_txn("and_after_rst", 3'b010, 16'hF0F0, 16'h0FF0, 0, '{16'h00F0, 16'h0000, 0, 0, 0, 2});

        // Reset while a result is held under backpressure
        start_and_wait("rst_done", 3'b000, 16'h0001, 16'h0001, lat);
        check("rst_done.pre_valid", {OutValid, ResLo}, {1'b1, 16'h0002});
        #2; Reset_n = 1'b0; #1;
        check("rst_done.hs", {InReady, OutValid}, 2'b10);
        check("rst_done.outputs", {ResHi, ResLo, ZeroFlag, CarryFlag, Err}, 35'h0);
        @(posedge Clock); #3; Reset_n = 1'b1;

        for (int n = 0; n < 40; n++) begin
            rc = 3'($urandom);
            ra = (n % 5 == 0) ? 16'hFFFF : 16'($urandom);
            rb = (n % 7 == 0) ? ra : 16'($urandom);
            e  = model(rc, ra, rb);
            run_txn($sformatf("rand%0d_cmd%0d", n, rc), rc, ra, rb, int'($urandom_range(0, 3)), e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
